alu_issue_seq: RTL and testbench
================================

Name: alu_issue_seq

Overview:
- Sequencer that sits directly upstream and downstream of the gate-level 32-bit ALU.
- Accepts one operation request over a valid/ready handshake and drives the ALU operand and selector inputs from registers.
- Holds those inputs stable for a programmable settle window covering the ALU's gate-delay propagation.
- Captures the ALU result and flags, post-processes SLT, and presents a registered response over a second valid/ready handshake.

Parameters:
- SETTLE_CYCLES, 4: clock cycles the ALU inputs are held before capture; legal range 1..255.
- CNT_W, 8: width of the settle counter; must hold SETTLE_CYCLES-1.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request this cycle.
- req_a  in  32  operand A.
- req_b  in  32  operand B.
- req_op  in  3  ALU command: 0 ADD, 1 SUB, 2 XOR, 3 SLT, 4 AND, 5 NAND, 6 NOR, 7 OR.
- alu_a  out  32  registered operand A to ALU.
- alu_b  out  32  registered operand B to ALU.
- alu_sel  out  3  registered selector to ALU.
- alu_out  in  32  ALU result.
- alu_carry  in  1  ALU carry flag.
- alu_over  in  1  ALU overflow flag.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts the response.
- rsp_result  out  32  final result.
- rsp_carry  out  1  final carry.
- rsp_over  out  1  final overflow.
- rsp_zero  out  1  final result == 0.
- rsp_op  out  3  op that produced the response.
- busy  out  1  high in SETTLE or HOLD.

Behaviour:
- Reset: all outputs 0 except req_ready=1. State IDLE, counter 0. The reset value of req_ready follows from state IDLE.
- States: IDLE, SETTLE, HOLD.
- req_ready = (state==IDLE) | (state==HOLD & rsp_ready). This is a combinational path from rsp_ready.
- Accept: the accept edge is a rising edge with req_valid & req_ready. On it:
  - alu_a/alu_b/alu_sel <= req_a/req_b/req_op.
  - The op is latched.
  - counter <= SETTLE_CYCLES-1.
  - state <= SETTLE.
- alu_a/alu_b/alu_sel change only on an accept edge. They hold stable through SETTLE and HOLD and keep their last value in IDLE.
- SETTLE: each edge with counter != 0 decrements the counter. The edge with counter==0 captures the response, sets rsp_valid <= 1 and moves to HOLD.
- Latency: with the accept edge at T, capture occurs at edge T+SETTLE_CYCLES, and rsp_valid is high from that edge.
- Capture rules:
  - ADD/SUB: rsp_result=alu_out, rsp_carry=alu_carry, rsp_over=alu_over.
  - SLT: rsp_result={31'b0, alu_out[31]^alu_over}, rsp_carry=0, rsp_over=0.
  - XOR/AND/NAND/NOR/OR: rsp_result=alu_out, rsp_carry=0, rsp_over=0.
  - rsp_zero is computed locally from the final rsp_result (NOR-reduce). The ALU's own zero flag is not used.
  - rsp_op = latched op.
- HOLD: rsp_* are stable while rsp_valid & !rsp_ready. When rsp_ready is high:
  - If req_valid is also high, perform an accept (back-to-back): rsp_valid <= 0, state <= SETTLE.
  - Otherwise rsp_valid <= 0 and state <= IDLE.
  - In both cases rsp_result and the flags retain their value; only rsp_valid qualifies them.
- req_valid while busy (not in HOLD with rsp_ready) is ignored. The requester must hold its request until req_ready.
- Reset mid-operation (SETTLE or HOLD): the in-flight op is dropped. No response is produced and the block returns to the reset values, except alu_a/alu_b/alu_sel, which clear to 0.
- SETTLE_CYCLES=1: capture on the first edge after accept.
- Throughput: one op per SETTLE_CYCLES+1 cycles at best (back-to-back).

Test Plan:
- ADD a=0xFFFFFFFF, b=0x00000001, SETTLE_CYCLES=4 -> rsp_valid rises exactly 4 edges after accept; rsp_result=0, carry=1, over=0, zero=1, rsp_op=0.
- SUB a=0x80000000, b=0x00000001 -> rsp_result=0x7FFFFFFF, carry=1, over=1, zero=0. Then SLT a=0xFFFFFFFF, b=0x00000001 -> rsp_result=0x00000001, carry=0, over=0. Then SLT a=5, b=5 -> rsp_result=0, zero=1.
- AND a=0xF0F0F0F0, b=0x0FF00FF0 with rsp_ready held low 6 cycles -> rsp_result=0x00F000F0 stable and rsp_valid high all 6 cycles; req_ready=0 throughout; alu_a/alu_b unchanged.
- Back-to-back: in HOLD, assert rsp_ready and req_valid together (OR a=0x1, b=0x2) -> first response consumed, second accepted on the same edge; second rsp_result=0x3 after SETTLE_CYCLES edges; no idle cycle in between.
- Reset asserted during SETTLE (counter=2) -> next edge: rsp_valid=0, busy=0, req_ready=1, alu_sel=0; no response ever appears for that op.
- Stall check: req_valid held high throughout SETTLE with changing req_a -> alu_a stays at the value from the accept edge until the next legal accept.

Source files
------------

// File: rtl/alu_issue_seq.sv
// alu_issue_seq: registers ALU inputs, waits a settle window, captures and post-processes the result
module alu_issue_seq #(
  parameter int SETTLE_CYCLES = 4,
  parameter int CNT_W = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  input  logic [2:0]  req_op,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [2:0]  alu_sel,
  input  logic [31:0] alu_out,
  input  logic        alu_carry,
  input  logic        alu_over,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_result,
  output logic        rsp_carry,
  output logic        rsp_over,
  output logic        rsp_zero,
  output logic [2:0]  rsp_op,
  output logic        busy
);
  typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_t;
  state_t state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic accept, capture, release_rsp, is_arith, is_slt;
  logic [31:0] res;
  assign req_ready = (state == IDLE) | (state == HOLD & rsp_ready);
  assign busy = state != IDLE;
  assign accept = req_valid & req_ready;
  assign capture = state == SETTLE && cnt == '0;
  assign release_rsp = state == HOLD && rsp_ready;
  // alu_sel doubles as the latched op: it only changes on accept
  assign is_arith = alu_sel == 3'd0 || alu_sel == 3'd1;
  assign is_slt = alu_sel == 3'd3;
  assign res = is_slt ? {31'b0, alu_out[31] ^ alu_over} : alu_out;
  always_comb begin
    state_nxt = state;
    state_nxt = accept ? SETTLE : capture ? HOLD : release_rsp ? IDLE : state;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_sel    <= '0;
      rsp_valid  <= 1'b0;
      rsp_result <= '0;
      rsp_carry  <= 1'b0;
      rsp_over   <= 1'b0;
      rsp_zero   <= 1'b0;
      rsp_op     <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        alu_a   <= req_a;
        alu_b   <= req_b;
        alu_sel <= req_op;
        cnt     <= CNT_W'(SETTLE_CYCLES - 1);
      end else if (state == SETTLE && cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
      if (capture) begin
        rsp_valid  <= 1'b1;
        rsp_result <= res;
        rsp_carry  <= is_arith & alu_carry;
        rsp_over   <= is_arith & alu_over;
        rsp_zero   <= ~|res;
        rsp_op     <= alu_sel;
      end else if (release_rsp) begin
        rsp_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_alu_issue_seq.sv
// tb_alu_issue_seq: directed checks of alu_issue_seq against a behavioural ALU model
module tb_alu_issue_seq;
  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready;
  logic [31:0] req_a, req_b;
  logic [2:0]  req_op;
  logic [31:0] alu_a, alu_b, alu_out;
  logic [2:0]  alu_sel;
  logic        alu_carry, alu_over;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_result;
  logic        rsp_carry, rsp_over, rsp_zero, busy;
  logic [2:0]  rsp_op;
  int passed = 0;
  int total = 0;

  always #5 clk = ~clk;

  alu_issue_seq #(.SETTLE_CYCLES(4), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
    .alu_out(alu_out), .alu_carry(alu_carry), .alu_over(alu_over),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_carry(rsp_carry), .rsp_over(rsp_over), .rsp_zero(rsp_zero),
    .rsp_op(rsp_op), .busy(busy)
  );

  // behavioural stand-in for the gate-level ALU; SLT reports the subtraction
  logic [32:0] sum, diff;
  assign sum  = {1'b0, alu_a} + {1'b0, alu_b};
  assign diff = {1'b0, alu_a} + {1'b0, ~alu_b} + 33'd1;
  always_comb begin
    alu_out = '0;
    alu_carry = 1'b0;
    alu_over = 1'b0;
    case (alu_sel)
      3'd0: begin
        alu_out = sum[31:0];
        alu_carry = sum[32];
        alu_over = (alu_a[31] == alu_b[31]) && (sum[31] != alu_a[31]);
      end
      3'd1, 3'd3: begin
        alu_out = diff[31:0];
        alu_carry = diff[32];
        alu_over = (alu_a[31] != alu_b[31]) && (diff[31] != alu_a[31]);
      end
      3'd2: alu_out = alu_a ^ alu_b;
      3'd4: alu_out = alu_a & alu_b;
      3'd5: alu_out = ~(alu_a & alu_b);
      3'd6: alu_out = ~(alu_a | alu_b);
      default: alu_out = alu_a | alu_b;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
    req_valid = 1'b1;
    req_a = a;
    req_b = b;
    req_op = op;
    step();
    req_valid = 1'b0;
  endtask

  task automatic settle();
    for (int i = 0; i < 3; i++) begin
      step();
      chk("settle_no_valid", 32'(rsp_valid), 32'd0);
    end
    step();
    chk("capture_valid", 32'(rsp_valid), 32'd1);
  endtask

  task automatic consume();
    rsp_ready = 1'b1;
    step();
    chk("consume_valid", 32'(rsp_valid), 32'd0);
    chk("consume_idle", 32'(busy), 32'd0);
    rsp_ready = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    req_valid = 1'b0;
    req_a = '0;
    req_b = '0;
    req_op = '0;
    rsp_ready = 1'b0;
    step();
    step();
    reset = 1'b0;
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_alu_a", alu_a, 32'd0);
    chk("rst_alu_sel", 32'(alu_sel), 32'd0);
    chk("rst_result", rsp_result, 32'd0);

    accept(32'hFFFF_FFFF, 32'h1, 3'd0);
    chk("add_busy", 32'(busy), 32'd1);
    chk("add_req_ready", 32'(req_ready), 32'd0);
    settle();
    chk("add_result", rsp_result, 32'd0);
    chk("add_carry", 32'(rsp_carry), 32'd1);
    chk("add_over", 32'(rsp_over), 32'd0);
    chk("add_zero", 32'(rsp_zero), 32'd1);
    chk("add_op", 32'(rsp_op), 32'd0);
    consume();

    accept(32'h8000_0000, 32'h1, 3'd1);
    settle();
    chk("sub_result", rsp_result, 32'h7FFF_FFFF);
    chk("sub_carry", 32'(rsp_carry), 32'd1);
    chk("sub_over", 32'(rsp_over), 32'd1);
    chk("sub_zero", 32'(rsp_zero), 32'd0);
    consume();

    accept(32'hFFFF_FFFF, 32'h1, 3'd3);
    settle();
    chk("slt_neg_result", rsp_result, 32'h1);
    chk("slt_neg_carry", 32'(rsp_carry), 32'd0);
    chk("slt_neg_over", 32'(rsp_over), 32'd0);
    chk("slt_neg_op", 32'(rsp_op), 32'd3);
    consume();

    accept(32'd5, 32'd5, 3'd3);
    settle();
    chk("slt_eq_result", rsp_result, 32'd0);
    chk("slt_eq_zero", 32'(rsp_zero), 32'd1);
    consume();

    accept(32'hF0F0_F0F0, 32'h0FF0_0FF0, 3'd4);
    settle();
    for (int i = 0; i < 6; i++) begin
      chk("and_hold_valid", 32'(rsp_valid), 32'd1);
      chk("and_hold_result", rsp_result, 32'h00F0_00F0);
      chk("and_hold_req_ready", 32'(req_ready), 32'd0);
      chk("and_hold_alu_a", alu_a, 32'hF0F0_F0F0);
      chk("and_hold_alu_b", alu_b, 32'h0FF0_0FF0);
      step();
    end

    rsp_ready = 1'b1;
    req_valid = 1'b1;
    req_a = 32'h1;
    req_b = 32'h2;
    req_op = 3'd7;
    #1;
    chk("b2b_req_ready", 32'(req_ready), 32'd1);
    step();
    rsp_ready = 1'b0;
    req_valid = 1'b0;
    chk("b2b_valid_drop", 32'(rsp_valid), 32'd0);
    chk("b2b_busy", 32'(busy), 32'd1);
    chk("b2b_alu_a", alu_a, 32'h1);
    chk("b2b_alu_sel", 32'(alu_sel), 32'd7);
    chk("b2b_result_retained", rsp_result, 32'h00F0_00F0);
    settle();
    chk("or_result", rsp_result, 32'h3);
    chk("or_op", 32'(rsp_op), 32'd7);
    chk("or_carry", 32'(rsp_carry), 32'd0);
    consume();

    accept(32'h0000_AAAA, 32'h0000_5555, 3'd2);
    req_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      req_a = 32'h100 + 32'(i);
      step();
      chk("stall_alu_a", alu_a, 32'h0000_AAAA);
    end
    chk("xor_valid", 32'(rsp_valid), 32'd1);
    chk("xor_result", rsp_result, 32'h0000_FFFF);
    req_a = 32'h1234;
    req_b = 32'h1;
    req_op = 3'd0;
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    req_valid = 1'b0;
    chk("stall_new_alu_a", alu_a, 32'h1234);
    settle();
    chk("stall_add_result", rsp_result, 32'h1235);
    consume();

    accept(32'h1, 32'h1, 3'd5);
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("midrst_valid", 32'(rsp_valid), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_req_ready", 32'(req_ready), 32'd1);
    chk("midrst_alu_sel", 32'(alu_sel), 32'd0);
    chk("midrst_alu_a", alu_a, 32'd0);
    for (int i = 0; i < 8; i++) begin
      step();
      chk("midrst_no_rsp", 32'(rsp_valid), 32'd0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
